vga_cmd_sched: RTL
==================

# vga_cmd_sched

Command scheduler that sits in front of the sprite/background/font update ports of `main_logic` and lets two requesters share them: game logic on port 0 and host on port 1. It arbitrates round-robin between the requesters and decodes one command word per grant. It sequences the matching control pulses, with strobe stretching for background and font changes. Optionally, it defers sprite updates to vertical blank so frames do not tear.

## Interface
Parameters:
- `STROBE_CYCLES`, default 4: cycles that `bchange_active`/`fchange_active` stay high per command (≥2).
- `SYNC_SPRITES`, default 1: when 1, sprite commands wait for `vblank`.

Ports:
- `clk`  in  1  system clock (100 MHz domain of `main_logic`).
- `rst_n`  in  1  asynchronous, active-low reset.
- `vblank`  in  1  vertical-blank flag, already synchronous to `clk`.
- `r0_valid`, `r1_valid`  in  1  command request.
- `r0_ready`, `r1_ready`  out  1  command accepted this cycle when `valid & ready`.
- `r0_cmd`, `r1_cmd`  in  32  command word; layout in Operation.
- `busy`  out  1  high whenever state ≠ IDLE.
- `x` out 10, `y` out 9, `visable` out 1, `sprite_sel` out 5: sprite fields.
- `load_pos`, `load_att`  out  1  single-cycle sprite load strobes.
- `background_sel` out 2, `bchange_active` out 1: background select and strobe.
- `fwaddr` out 11, `fwdata` out 4, `fwenable` out 1, `fchange_active` out 1: font write.

## Operation
- Command word fields:
  - op = cmd[31:30]: 00 SPR_POS, 01 SPR_ATT, 10 BKG, 11 FONT.
  - Sprite ops: sel = cmd[29:25], visable = cmd[19], x = cmd[18:9], y = cmd[8:0].
  - BKG: background_sel = cmd[1:0].
  - FONT: fwaddr = cmd[14:4], fwdata = cmd[3:0].
  - All other bits are ignored.
- Arbitration:
  - Only IDLE grants.
  - If one requester is valid, it is granted.
  - If both are valid, the requester not served last is granted.
  - `last` resets to 1, so port 0 wins the first tie.
  - `rN_ready` = (state==IDLE) & grantN, combinational from valid and `last`. At most one ready is high at a time.
- FSM states:
  - IDLE: on a handshake, capture the command.
    - Sprite op with SYNC_SPRITES=1 and vblank=0 → WAIT_VB.
    - Any other op → ISSUE.
  - WAIT_VB: stay until vblank=1, then → ISSUE. If vblank drops while waiting, keep waiting.
  - ISSUE:
    - Load the field outputs for the op.
    - Sprite op: pulse `load_pos` or `load_att` for this cycle only, then → IDLE.
    - BKG/FONT: assert the strobe and → HOLD. For FONT, `fwenable` is asserted together with `fchange_active`.
  - HOLD: keep the strobe high until it has been high for STROBE_CYCLES cycles in total, then → GAP.
  - GAP: all strobes low for one cycle, so the downstream stretch counter clears, then → IDLE.
- Field outputs hold their last issued value between commands. Fields belonging to other ops are not disturbed.
- `busy` covers WAIT_VB, ISSUE, HOLD and GAP.
- Reset (asynchronous, any state, including mid-strobe):
  - State → IDLE, `last` → 1.
  - All strobes, `busy`, `visable` and fields → 0.
  - A captured command is dropped.

## Timing
- All outputs except `rN_ready` are registered.
- Handshake at edge T:
  - Unsynchronised or in-vblank sprite command: `load_pos`/`load_att` high during cycle T+1, back in IDLE at T+2 (next accept at T+2).
  - Deferred sprite command: strobe high in the cycle after the first edge that samples vblank=1 in WAIT_VB.
  - BKG/FONT: strobe high during cycles T+1 .. T+STROBE_CYCLES, GAP at T+STROBE_CYCLES+1, next accept at T+STROBE_CYCLES+2.
- Throughput: one command per 2 cycles for sprites, one per STROBE_CYCLES+2 cycles for BKG/FONT.
- A requester that drops valid before ready is simply not served; no state is kept.

## Structure
- Package `vga_cmd_pkg`: op encodings, command-word field bit positions, state enumeration.
- Sub-module `rr_arb2`: two-request round-robin grant with a `last` register, updated on handshake.
- Top level: FSM, hold counter sized to STROBE_CYCLES, output registers.

## Test plan
- Reset, then r0 sends SPR_POS sel=3, x=320, y=200, visable=1 with vblank=1 → `load_pos` high exactly at T+1 with those field values; `r0_ready` high again at T+2.
- SYNC_SPRITES=1, vblank=0, r1 sends SPR_ATT → no `load_att` and `busy`=1. Raise vblank 10 cycles later → `load_att` one cycle after vblank is sampled.
- r0 sends BKG sel=2 → `bchange_active` high for exactly 4 cycles, then 1 low cycle; `background_sel`=2 holds afterwards.
- Both requesters valid continuously → grants alternate r0, r1, r0, …; first grant goes to r0.
- FONT fwaddr=0x5A5, fwdata=0xC → `fwenable` and `fchange_active` high for 4 cycles with those values.
- Assert `rst_n` low in the 2nd HOLD cycle → all strobes and `busy` go 0 immediately; after release the next tie grants r0.

Source files
------------

// File: rtl/vga_cmd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_cmd_pkg
//  Purpose  : Shared opcodes, command-word field positions and scheduler
//             state encoding for vga_cmd_sched.
//  Revision : 1.0  initial release
// ============================================================================
package vga_cmd_pkg;

  // Opcode encodings carried in cmd[31:30]
  localparam logic [1:0] c_OP_SPR_POS = 2'b00;
  localparam logic [1:0] c_OP_SPR_ATT = 2'b01;
  localparam logic [1:0] c_OP_BKG     = 2'b10;
  localparam logic [1:0] c_OP_FONT    = 2'b11;

  // Command-word field bit positions
  localparam int c_OP_HI    = 31;
  localparam int c_OP_LO    = 30;
  localparam int c_SEL_HI   = 29;
  localparam int c_SEL_LO   = 25;
  localparam int c_VIS_BIT  = 19;
  localparam int c_X_HI     = 18;
  localparam int c_X_LO     = 9;
  localparam int c_Y_HI     = 8;
  localparam int c_Y_LO     = 0;
  localparam int c_BSEL_HI  = 1;
  localparam int c_BSEL_LO  = 0;
  localparam int c_FADDR_HI = 14;
  localparam int c_FADDR_LO = 4;
  localparam int c_FDATA_HI = 3;
  localparam int c_FDATA_LO = 0;

  // Scheduler states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_VB = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_HOLD    = 3'd3,
    ST_GAP     = 3'd4
  } state_e;

  // Both sprite opcodes have a zero MSB
  function automatic logic is_sprite(input logic [1:0] op);
    return (op[1] == 1'b0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb2
//  Purpose  : Two-request round-robin arbiter. A grant is only issued while
//             en_i is high; on a tie the requester not served last wins.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic req0_i,
  input  logic req1_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  // 1 means port 1 was served last, so port 0 wins the first tie
  logic last_q;

  // Grant decode: single requester always wins, ties go against last_q
  always_comb begin
    gnt0_o = en_i & req0_i & (~req1_i | last_q);
    gnt1_o = en_i & req1_i & (~req0_i | ~last_q);
  end

  // Remember which port was served; a grant is itself a handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (gnt0_o) begin
      last_q <= 1'b0;
    end else if (gnt1_o) begin
      last_q <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_cmd_sched.sv
`default_nettype none
// ============================================================================
//  Module   : vga_cmd_sched
//  Purpose  : Shares the sprite/background/font update ports of main_logic
//             between two requesters. Decodes one command per grant, issues
//             the matching pulses, stretches background/font strobes and
//             optionally defers sprite updates to vertical blank.
//  Revision : 1.0  initial release
// ============================================================================
module vga_cmd_sched
  import vga_cmd_pkg::*;
#(
  parameter int STROBE_CYCLES = 4,
  parameter bit SYNC_SPRITES  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vblank,
  input  logic        r0_valid,
  input  logic        r1_valid,
  output logic        r0_ready,
  output logic        r1_ready,
  input  logic [31:0] r0_cmd,
  input  logic [31:0] r1_cmd,
  output logic        busy,
  output logic [9:0]  x,
  output logic [8:0]  y,
  output logic        visable,
  output logic [4:0]  sprite_sel,
  output logic        load_pos,
  output logic        load_att,
  output logic [1:0]  background_sel,
  output logic        bchange_active,
  output logic [10:0] fwaddr,
  output logic [3:0]  fwdata,
  output logic        fwenable,
  output logic        fchange_active
);

  localparam int c_CNT_W = $clog2(STROBE_CYCLES + 1);

  state_e              state_q, state_d;
  logic [31:0]         cmd_q, cmd_d;
  logic [c_CNT_W-1:0]  cnt_q, cnt_d;

  logic                busy_q, busy_d;
  logic [9:0]          x_q, x_d;
  logic [8:0]          y_q, y_d;
  logic                vis_q, vis_d;
  logic [4:0]          ssel_q, ssel_d;
  logic                lpos_q, lpos_d;
  logic                latt_q, latt_d;
  logic [1:0]          bsel_q, bsel_d;
  logic                bchg_q, bchg_d;
  logic [10:0]         faddr_q, faddr_d;
  logic [3:0]          fdata_q, fdata_d;
  logic                fwen_q, fwen_d;
  logic                fchg_q, fchg_d;

  logic                w_gnt0, w_gnt1, w_hs;
  logic [31:0]         w_req_cmd;
  logic                w_issue;
  logic [31:0]         w_icmd;
  logic                w_unused_bits;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (state_q == ST_IDLE),
    .req0_i (r0_valid),
    .req1_i (r1_valid),
    .gnt0_o (w_gnt0),
    .gnt1_o (w_gnt1)
  );

  assign r0_ready  = w_gnt0;
  assign r1_ready  = w_gnt1;
  assign w_hs      = w_gnt0 | w_gnt1;
  assign w_req_cmd = w_gnt0 ? r0_cmd : r1_cmd;

  // Reserved command bits carry no meaning
  assign w_unused_bits = ^{r0_cmd[24:20], r1_cmd[24:20], cmd_q[24:20]};

  // Next-state, command capture and output-register next values
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    vis_d   = vis_q;
    ssel_d  = ssel_q;
    bsel_d  = bsel_q;
    faddr_d = faddr_q;
    fdata_d = fdata_q;
    lpos_d  = 1'b0;
    latt_d  = 1'b0;
    bchg_d  = bchg_q;
    fchg_d  = fchg_q;
    fwen_d  = fwen_q;
    w_issue = 1'b0;
    w_icmd  = cmd_q;

    case (state_q)
      ST_IDLE: begin
        if (w_hs) begin
          cmd_d = w_req_cmd;
          if (is_sprite(w_req_cmd[c_OP_HI:c_OP_LO]) && SYNC_SPRITES && !vblank) begin
            state_d = ST_WAIT_VB;
          end else begin
            w_issue = 1'b1;
            w_icmd  = w_req_cmd;
          end
        end
      end
      ST_WAIT_VB: begin
        if (vblank) begin
          w_issue = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (is_sprite(cmd_q[c_OP_HI:c_OP_LO])) begin
          state_d = ST_IDLE;
        end else begin
          // Strobe has been high for one cycle; the next is the second
          state_d = ST_HOLD;
          cnt_d   = c_CNT_W'(2);
        end
      end
      ST_HOLD: begin
        if (cnt_q == c_CNT_W'(STROBE_CYCLES)) begin
          state_d = ST_GAP;
          bchg_d  = 1'b0;
          fchg_d  = 1'b0;
          fwen_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + c_CNT_W'(1);
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Registering the decoded fields here makes them visible during ISSUE
    if (w_issue) begin
      state_d = ST_ISSUE;
      case (w_icmd[c_OP_HI:c_OP_LO])
        c_OP_SPR_POS, c_OP_SPR_ATT: begin
          ssel_d = w_icmd[c_SEL_HI:c_SEL_LO];
          vis_d  = w_icmd[c_VIS_BIT];
          x_d    = w_icmd[c_X_HI:c_X_LO];
          y_d    = w_icmd[c_Y_HI:c_Y_LO];
          lpos_d = (w_icmd[c_OP_HI:c_OP_LO] == c_OP_SPR_POS);
          latt_d = (w_icmd[c_OP_HI:c_OP_LO] == c_OP_SPR_ATT);
        end
        c_OP_BKG: begin
          bsel_d = w_icmd[c_BSEL_HI:c_BSEL_LO];
          bchg_d = 1'b1;
        end
        default: begin
          faddr_d = w_icmd[c_FADDR_HI:c_FADDR_LO];
          fdata_d = w_icmd[c_FDATA_HI:c_FDATA_LO];
          fchg_d  = 1'b1;
          fwen_d  = 1'b1;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State, captured command and hold counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      vis_q   <= 1'b0;
      ssel_q  <= '0;
      lpos_q  <= 1'b0;
      latt_q  <= 1'b0;
      bsel_q  <= '0;
      bchg_q  <= 1'b0;
      faddr_q <= '0;
      fdata_q <= '0;
      fwen_q  <= 1'b0;
      fchg_q  <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      x_q     <= x_d;
      y_q     <= y_d;
      vis_q   <= vis_d;
      ssel_q  <= ssel_d;
      lpos_q  <= lpos_d;
      latt_q  <= latt_d;
      bsel_q  <= bsel_d;
      bchg_q  <= bchg_d;
      faddr_q <= faddr_d;
      fdata_q <= fdata_d;
      fwen_q  <= fwen_d;
      fchg_q  <= fchg_d;
    end
  end

  assign busy           = busy_q;
  assign x              = x_q;
  assign y              = y_q;
  assign visable        = vis_q;
  assign sprite_sel     = ssel_q;
  assign load_pos       = lpos_q;
  assign load_att       = latt_q;
  assign background_sel = bsel_q;
  assign bchange_active = bchg_q;
  assign fwaddr         = faddr_q;
  assign fwdata         = fdata_q;
  assign fwenable       = fwen_q;
  assign fchange_active = fchg_q;

endmodule
`default_nettype wire
